// File: rtl/fifo_sync_ctrl_pkg.sv
// fifo_sync_ctrl_pkg: shared occupancy encoding, width helper and default sizes for fifo_sync_ctrl.
package fifo_sync_ctrl_pkg;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/fifo_sync_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NUM_REQ requesters, priority pointer advances past each winner.
module rr_arbiter
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);
  localparam int PW = clog2w(NUM_REQ);
  logic [PW-1:0] rr_pri_q, rr_pri_d;
  logic [NUM_REQ-1:0] gnt_c;
  logic found;
  int idx;
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx = 0;
    rr_pri_d = rr_pri_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_pri_q) + k) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found = 1'b1;
        gnt_c[idx] = 1'b1;
        rr_pri_d = PW'((idx + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk) rr_pri_q <= rst ? '0 : rr_pri_d;
  assign gnt = gnt_c;
endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: pointer/count/flag controller for a dual-port FIFO memory with round-robin write port sharing.
// Optional sticky overflow/underflow error flags are built when FIFO_SYNC_CTRL_ERR_EN is defined.
module fifo_sync_ctrl
  import fifo_sync_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH  = clog2w(DEF_DEPTH),
  parameter int NUM_REQ    = 2,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic                          mem_wr_en,
  output logic [PTR_WIDTH-1:0]          mem_wr_ptr,
  output logic [DATA_WIDTH-1:0]         mem_d_in,
  output logic                          mem_rd_en,
  output logic [PTR_WIDTH-1:0]          mem_rd_ptr,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [PTR_WIDTH:0]            count
`ifdef FIFO_SYNC_CTRL_ERR_EN
  ,
  input  logic                          err_clr,
  output logic                          ovf_err,
  output logic                          unf_err
`endif
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic rd_valid_q, rd_valid_d;
  logic push, pop;
  logic [DATA_WIDTH-1:0] d_in;
  occ_e occ;
  // Flags come only from the registered count so no input reaches them combinationally.
  always_comb begin
    occ = (count_q == '0) ? OCC_EMPTY : (count_q == DEPTH_C) ? OCC_FULL : OCC_PARTIAL;
    full = occ == OCC_FULL;
    empty = occ == OCC_EMPTY;
    almost_full = count_q >= AF_C;
    almost_empty = count_q <= AE_C;
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req),
    .enable(!full),
    .gnt   (wr_gnt)
  );
  always_comb begin
    d_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (wr_gnt[i]) d_in = d_in | wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    push = |wr_gnt;
    pop = rd_req & !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    rd_valid_d = pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign mem_wr_en = push;
  assign mem_wr_ptr = wr_ptr_q;
  assign mem_d_in = d_in;
  assign mem_rd_en = pop;
  assign mem_rd_ptr = rd_ptr_q;
  assign rd_valid = rd_valid_q;
  assign count = count_q;
`ifdef FIFO_SYNC_CTRL_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  // A new error in the clearing cycle survives the clear.
  always_comb begin
    ovf_d = (|wr_req & full) | (ovf_q & !err_clr);
    unf_d = (rd_req & empty) | (unf_q & !err_clr);
  end
  always_ff @(posedge clk) begin
    ovf_q <= rst ? 1'b0 : ovf_d;
    unf_q <= rst ? 1'b0 : unf_d;
  end
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif
endmodule
